instr_fetch_unit: RTL

//  Instruction-fetch stage directly downstream of the program counter in the multicycle CPU.
//  - On a fetch command from the control unit, takes the current PC value and reads the word at that address from instruction memory over a req/ack handshake.
//  - Latches the word into the instruction register and produces PC+4 for the next-PC mux.
//  - Reports completion or fault back to the control FSM.

---
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: reads the word at the current PC over a req/ack handshake,
// latches it into the IR and produces PC+4. Optional fetch timeout under FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_done,
  output logic              fetch_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] ir_q;
  logic [ADDR_W-1:0] pc_plus4_q;
  logic              req_q;
  logic              done_q;
  logic              err_q;
  logic              busy_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values together; a blocking = would leak new state into later lines.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      ir_q       <= '0;
      pc_plus4_q <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fetch_start) begin
            addr_q <= pc_in;
            busy_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            cnt_q  <= '0;
`endif
            // A misaligned PC never reaches memory.
            if (pc_in[1:0] != 2'b00) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (imem_ack) begin
            ir_q       <= imem_rdata;
            pc_plus4_q <= addr_q + ADDR_W'(4);
            req_q      <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ERR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        DONE, ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ir_out     = ir_q;
  assign pc_plus4   = pc_plus4_q;
  assign fetch_done = done_q;
  assign fetch_err  = err_q;
  assign busy       = busy_q;

endmodule
